// File: rtl/meduram_pkg.sv
// Shared helpers for the read scheduler: the bank-select width rule and the
// round-robin search, which works on a fixed 32-bit vector so arbiters of any size up to 32 can use it.
package meduram_pkg;

  localparam int RR_MAXW = 32;

  typedef logic [RR_MAXW-1:0] rr_vec_t;

  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Search starts at ptr and wraps at n; the first requester found wins.
  function automatic rr_vec_t rr_grant(input rr_vec_t req, input int ptr, input int n);
    rr_vec_t g;
    int      idx;
    g = '0;
    for (int k = 0; k < RR_MAXW; k++) begin
      if (k < n && g == '0) begin
        idx = (ptr + k) % n;
        if (req[idx[4:0]]) g[idx[4:0]] = 1'b1;
      end
    end
    return g;
  endfunction

  function automatic int rr_index(input rr_vec_t g);
    int r;
    r = 0;
    for (int k = 0; k < RR_MAXW; k++) begin
      if (g[k]) r = k;
    end
    return r;
  endfunction

  function automatic int rr_next(input int granted, input int n);
    return (granted + 1) % n;
  endfunction

endpackage

// File: rtl/read_scheduler_if.sv
// Agent request/response and read-switch signals of the read scheduler.
// master = agents plus switch side, slave = the scheduler.
interface read_scheduler_if #(
  parameter int ADDR_WIDTH   = 8,
  parameter int DATA_WIDTH   = 32,
  parameter int NB_RDAGENT   = 2,
  parameter int SELECT_WIDTH = 1
);
  logic [NB_RDAGENT-1:0]              req_valid;
  logic [NB_RDAGENT-1:0]              req_ready;
  logic [NB_RDAGENT*ADDR_WIDTH-1:0]   req_addr;
  logic [NB_RDAGENT*SELECT_WIDTH-1:0] req_bank;
  logic [NB_RDAGENT-1:0]              sw_rden;
  logic [NB_RDAGENT*ADDR_WIDTH-1:0]   sw_rdaddr;
  logic [NB_RDAGENT*SELECT_WIDTH-1:0] sw_rdselect;
  logic [NB_RDAGENT*DATA_WIDTH-1:0]   sw_rddata;
  logic [NB_RDAGENT-1:0]              rsp_valid;
  logic [NB_RDAGENT-1:0]              rsp_err;
  logic [NB_RDAGENT*DATA_WIDTH-1:0]   rsp_data;

  modport master (
    output req_valid, req_addr, req_bank, sw_rddata,
    input  req_ready, sw_rden, sw_rdaddr, sw_rdselect, rsp_valid, rsp_err, rsp_data
  );

  modport slave (
    input  req_valid, req_addr, req_bank, sw_rddata,
    output req_ready, sw_rden, sw_rdaddr, sw_rdselect, rsp_valid, rsp_err, rsp_data
  );
endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant, pointer moves past the winner.
// Pointer only advances on a grant, so an idle cycle keeps the current priority.
module rr_arbiter
  import meduram_pkg::*;
#(
  parameter int N = 2
) (
  input  logic         aclk,
  input  logic         areset,
  input  logic [N-1:0] req,
  output logic [N-1:0] grant
);

  localparam int PW = sel_width(N);

  logic [PW-1:0] ptr;
  rr_vec_t       req_pad;
  rr_vec_t       gnt_pad;

  always_comb begin
    req_pad        = '0;
    req_pad[N-1:0] = req;
    gnt_pad        = rr_grant(req_pad, int'(ptr), N);
    grant          = gnt_pad[N-1:0];
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      ptr <= '0;
    end else if (|grant) begin
      ptr <= PW'(rr_next(rr_index(gnt_pad), N));
    end
  end

endmodule

// File: rtl/read_scheduler.sv
// Per-bank round-robin read scheduler: grant in cycle T, switch read at T+1,
// response at T+1+BANK_LATENCY; out-of-range banks are accepted at once and answered with an error.
module read_scheduler
  import meduram_pkg::*;
#(
  parameter int ADDR_WIDTH   = 8,
  parameter int DATA_WIDTH   = 32,
  parameter int NB_WRAGENT   = 2,
  parameter int NB_RDAGENT   = 2,
  parameter int SELECT_WIDTH = sel_width(NB_WRAGENT),
  parameter int BANK_LATENCY = 1
) (
  input  logic              aclk,
  input  logic              areset,
  read_scheduler_if.slave   bus
);

  logic [SELECT_WIDTH-1:0]            bank_sel [NB_RDAGENT];
  logic [NB_WRAGENT*NB_RDAGENT-1:0]   req_flat;
  logic [NB_WRAGENT*NB_RDAGENT-1:0]   gnt_flat;
  logic [NB_RDAGENT-1:0]              oor;
  logic [NB_RDAGENT-1:0]              granted;
  logic [NB_RDAGENT-1:0]              ready;
  logic [NB_RDAGENT-1:0]              vld_pipe [BANK_LATENCY+1];
  logic [NB_RDAGENT-1:0]              err_pipe [BANK_LATENCY+1];
  logic [NB_RDAGENT*ADDR_WIDTH-1:0]   addr_q;
  logic [NB_RDAGENT*SELECT_WIDTH-1:0] sel_q;
  logic [NB_RDAGENT-1:0]              rsp_vld;
  logic [NB_RDAGENT-1:0]              rsp_bad;
  logic [NB_RDAGENT*DATA_WIDTH-1:0]   rsp_dat;

  always_comb begin
    oor = '0;
    for (int i = 0; i < NB_RDAGENT; i++) begin
      bank_sel[i] = bus.req_bank[i*SELECT_WIDTH +: SELECT_WIDTH];
      oor[i]      = bus.req_valid[i] && !areset && (32'(bank_sel[i]) >= NB_WRAGENT);
    end
  end

  // Requests are masked during reset so no grant can move a pointer or fire a handshake.
  always_comb begin
    req_flat = '0;
    for (int b = 0; b < NB_WRAGENT; b++) begin
      for (int i = 0; i < NB_RDAGENT; i++) begin
        req_flat[b*NB_RDAGENT + i] = bus.req_valid[i] && !areset &&
                                     (32'(bank_sel[i]) == 32'(b));
      end
    end
  end

  for (genvar b = 0; b < NB_WRAGENT; b++) begin : g_bank
    rr_arbiter #(.N(NB_RDAGENT)) u_arb (
      .aclk   (aclk),
      .areset (areset),
      .req    (req_flat[b*NB_RDAGENT +: NB_RDAGENT]),
      .grant  (gnt_flat[b*NB_RDAGENT +: NB_RDAGENT])
    );
  end

  always_comb begin
    granted = '0;
    for (int b = 0; b < NB_WRAGENT; b++) begin
      for (int i = 0; i < NB_RDAGENT; i++) begin
        granted[i] = granted[i] | gnt_flat[b*NB_RDAGENT + i];
      end
    end
  end

  assign ready         = granted | oor;
  assign bus.req_ready = ready;

  // Stage 0 is the switch-issue cycle; stage BANK_LATENCY lines up with bank data.
  always_ff @(posedge aclk) begin
    if (areset) begin
      for (int k = 0; k <= BANK_LATENCY; k++) begin
        vld_pipe[k] <= '0;
        err_pipe[k] <= '0;
      end
      addr_q <= '0;
      sel_q  <= '0;
    end else begin
      vld_pipe[0] <= ready;
      err_pipe[0] <= oor;
      for (int k = 1; k <= BANK_LATENCY; k++) begin
        vld_pipe[k] <= vld_pipe[k-1];
        err_pipe[k] <= err_pipe[k-1];
      end
      for (int i = 0; i < NB_RDAGENT; i++) begin
        if (granted[i]) begin
          addr_q[i*ADDR_WIDTH +: ADDR_WIDTH]     <= bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
          sel_q[i*SELECT_WIDTH +: SELECT_WIDTH] <= bank_sel[i];
        end
      end
    end
  end

  assign bus.sw_rden     = vld_pipe[0] & ~err_pipe[0] & {NB_RDAGENT{~areset}};
  assign bus.sw_rdaddr   = areset ? '0 : addr_q;
  assign bus.sw_rdselect = areset ? '0 : sel_q;

  assign rsp_vld = vld_pipe[BANK_LATENCY] & {NB_RDAGENT{~areset}};
  assign rsp_bad = err_pipe[BANK_LATENCY] & rsp_vld;

  always_comb begin
    rsp_dat = '0;
    for (int i = 0; i < NB_RDAGENT; i++) begin
      if (rsp_vld[i] && !rsp_bad[i]) begin
        rsp_dat[i*DATA_WIDTH +: DATA_WIDTH] = bus.sw_rddata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign bus.rsp_valid = rsp_vld;
  assign bus.rsp_err   = rsp_bad;
  assign bus.rsp_data  = rsp_dat;

endmodule

// File: tb/tb_read_scheduler.sv
// Directed bench for read_scheduler: two instances (2 and 3 banks) with a
// registered one-cycle bank model preloaded with {A5, bank, 00, addr}.
module tb_read_scheduler;

  logic aclk;
  logic areset;

  read_scheduler_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .NB_RDAGENT(2), .SELECT_WIDTH(1)) bus ();
  read_scheduler_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .NB_RDAGENT(2), .SELECT_WIDTH(2)) bus3 ();

  read_scheduler #(.NB_WRAGENT(2)) dut (
    .aclk   (aclk),
    .areset (areset),
    .bus    (bus)
  );

  read_scheduler #(.NB_WRAGENT(3)) dut3 (
    .aclk   (aclk),
    .areset (areset),
    .bus    (bus3)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] mem [0:3][0:255];
  logic [63:0] rddata;
  logic [63:0] rddata3;

  assign bus.sw_rddata  = rddata;
  assign bus3.sw_rddata = rddata3;

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  initial begin
    for (int b = 0; b < 4; b++)
      for (int a = 0; a < 256; a++)
        mem[b][a] = {8'hA5, 8'(b), 8'h00, 8'(a)};
  end

  always @(posedge aclk) begin : bank_model
    logic [1:0] s;
    if (areset) begin
      rddata  <= '0;
      rddata3 <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (bus.sw_rden[i]) begin
          s = {1'b0, bus.sw_rdselect[i]};
          rddata[i*32 +: 32] <= mem[s][bus.sw_rdaddr[i*8 +: 8]];
        end
        if (bus3.sw_rden[i]) begin
          s = bus3.sw_rdselect[i*2 +: 2];
          rddata3[i*32 +: 32] <= mem[s][bus3.sw_rdaddr[i*8 +: 8]];
        end
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  int cnt0;
  int cnt1;

  initial begin
    areset         = 1'b1;
    bus.req_valid  = '0;
    bus.req_addr   = '0;
    bus.req_bank   = '0;
    bus3.req_valid = '0;
    bus3.req_addr  = '0;
    bus3.req_bank  = '0;
    repeat (3) tick();

    // Reset state with requests pending
    bus.req_valid = 2'b11;
    bus.req_bank  = 2'b00;
    bus.req_addr  = 16'h0201;
    @(negedge aclk);
    check("rst_ready",   64'(bus.req_ready), 64'h0);
    check("rst_rden",    64'(bus.sw_rden), 64'h0);
    check("rst_rvalid",  64'(bus.rsp_valid), 64'h0);
    check("rst_rerr",    64'(bus.rsp_err), 64'h0);
    check("rst_rdaddr",  64'(bus.sw_rdaddr), 64'h0);
    check("rst_rdsel",   64'(bus.sw_rdselect), 64'h0);
    check("rst_rdata",   bus.rsp_data, 64'h0);

    // Contention on bank 0 right at reset exit
    tick();
    areset = 1'b0;
    @(negedge aclk);
    check("c0_ready", 64'(bus.req_ready), 64'h1);
    tick();
    bus.req_valid = 2'b10;
    @(negedge aclk);
    check("c1_ready",  64'(bus.req_ready), 64'h2);
    check("c1_rden",   64'(bus.sw_rden), 64'h1);
    check("c1_rvalid", 64'(bus.rsp_valid), 64'h0);
    tick();
    bus.req_valid = 2'b00;
    @(negedge aclk);
    check("c2_rden",   64'(bus.sw_rden), 64'h2);
    check("c2_rdaddr", 64'(bus.sw_rdaddr), 64'h0201);
    check("c2_rvalid", 64'(bus.rsp_valid), 64'h1);
    check("c2_rdata",  bus.rsp_data, 64'h0000_0000_A500_0001);
    tick();
    @(negedge aclk);
    check("c3_rvalid", 64'(bus.rsp_valid), 64'h2);
    check("c3_rdata",  bus.rsp_data, 64'hA500_0002_0000_0000);
    check("c3_rden",   64'(bus.sw_rden), 64'h0);
    check("c3_hold",   64'(bus.sw_rdaddr), 64'h0201);
    tick();
    @(negedge aclk);
    check("c4_rvalid", 64'(bus.rsp_valid), 64'h0);
    check("c4_rdata",  bus.rsp_data, 64'h0);
    tick();

    // Distinct banks in the same cycle
    bus.req_valid = 2'b11;
    bus.req_bank  = 2'b10;
    bus.req_addr  = 16'h2010;
    @(negedge aclk);
    check("db_ready", 64'(bus.req_ready), 64'h3);
    tick();
    bus.req_valid = 2'b00;
    @(negedge aclk);
    check("db_rden",  64'(bus.sw_rden), 64'h3);
    check("db_rdsel", 64'(bus.sw_rdselect), 64'h2);
    check("db_rdaddr", 64'(bus.sw_rdaddr), 64'h2010);
    tick();
    @(negedge aclk);
    check("db_rvalid", 64'(bus.rsp_valid), 64'h3);
    check("db_rerr",   64'(bus.rsp_err), 64'h0);
    check("db_rdata",  bus.rsp_data, 64'hA501_0020_A500_0010);
    tick();

    // Both agents hold requests to bank 1 for 8 cycles
    bus.req_valid = 2'b11;
    bus.req_bank  = 2'b11;
    bus.req_addr  = 16'h0504;
    cnt0 = 0;
    cnt1 = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge aclk);
      check($sformatf("rr_ready_%0d", k), 64'(bus.req_ready), (k % 2 == 0) ? 64'h1 : 64'h2);
      if (bus.req_ready[0]) cnt0++;
      if (bus.req_ready[1]) cnt1++;
      tick();
    end
    check("rr_cnt0", 64'(cnt0), 64'd4);
    check("rr_cnt1", 64'(cnt1), 64'd4);
    bus.req_valid = 2'b00;
    bus.req_bank  = 2'b00;
    repeat (3) tick();

    // Agent 0 streams six reads to bank 0
    for (int k = 0; k < 9; k++) begin
      bus.req_valid = (k < 6) ? 2'b01 : 2'b00;
      bus.req_addr  = {8'h00, 8'h30 + 8'(k)};
      @(negedge aclk);
      if (k < 6) check($sformatf("st_ready_%0d", k), 64'(bus.req_ready), 64'h1);
      if (k >= 2 && k < 8) begin
        check($sformatf("st_rvalid_%0d", k), 64'(bus.rsp_valid), 64'h1);
        check($sformatf("st_rdata_%0d", k), bus.rsp_data, 64'hA500_0030 + 64'(k - 2));
      end
      if (k == 8) check("st_rvalid_end", 64'(bus.rsp_valid), 64'h0);
      tick();
    end

    // Reset one cycle after a handshake
    bus.req_valid = 2'b01;
    bus.req_bank  = 2'b00;
    bus.req_addr  = 16'h0044;
    @(negedge aclk);
    check("rs_ready", 64'(bus.req_ready), 64'h1);
    tick();
    bus.req_valid = 2'b00;
    areset        = 1'b1;
    @(negedge aclk);
    check("rs_rden",   64'(bus.sw_rden), 64'h0);
    check("rs_rvalid", 64'(bus.rsp_valid), 64'h0);
    tick();
    areset        = 1'b0;
    bus.req_valid = 2'b11;
    @(negedge aclk);
    check("rs_flush", 64'(bus.rsp_valid), 64'h0);
    check("rs_ptr0",  64'(bus.req_ready), 64'h1);
    tick();
    bus.req_valid = 2'b10;
    @(negedge aclk);
    check("rs_next", 64'(bus.req_ready), 64'h2);
    tick();
    bus.req_valid = 2'b00;
    repeat (3) tick();

    // Out-of-range bank on the three-bank instance
    bus3.req_valid = 2'b11;
    bus3.req_bank  = 4'b1110;
    bus3.req_addr  = 16'h5566;
    @(negedge aclk);
    check("oor_ready", 64'(bus3.req_ready), 64'h3);
    tick();
    bus3.req_valid = 2'b00;
    @(negedge aclk);
    check("oor_rden",   64'(bus3.sw_rden), 64'h1);
    check("oor_rdsel",  64'(bus3.sw_rdselect), 64'h2);
    check("oor_rdaddr", 64'(bus3.sw_rdaddr), 64'h0066);
    check("oor_early",  64'(bus3.rsp_valid), 64'h0);
    tick();
    @(negedge aclk);
    check("oor_rvalid", 64'(bus3.rsp_valid), 64'h3);
    check("oor_rerr",   64'(bus3.rsp_err), 64'h2);
    check("oor_rdata",  bus3.rsp_data, 64'h0000_0000_A502_0066);
    tick();
    @(negedge aclk);
    check("oor_done", 64'(bus3.rsp_valid), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/read_scheduler.md
READ_SCHEDULER -- requirements
Module: read_scheduler

Interface
REQ-001 Parameter ADDR_WIDTH, default 8, read address width in bits.
REQ-002 Parameter DATA_WIDTH, default 32, read data width in bits.
REQ-003 Parameter NB_WRAGENT, default 2, number of memory banks.
REQ-004 Parameter NB_RDAGENT, default 2, number of read agents.
REQ-005 Parameter SELECT_WIDTH, default max(1, clog2(NB_WRAGENT)), bank-index width.
REQ-006 Parameter BANK_LATENCY, default 1, cycles from bank enable to registered bank output.
REQ-007 aclk  in  1  sole clock; all logic on its rising edge.
REQ-008 areset  in  1  synchronous, active-high reset.
REQ-009 req_valid  in  NB_RDAGENT  per-agent read request.
REQ-010 req_ready  out  NB_RDAGENT  per-agent request accepted this cycle.
REQ-011 req_addr  in  NB_RDAGENT*ADDR_WIDTH  per-agent read address.
REQ-012 req_bank  in  NB_RDAGENT*SELECT_WIDTH  per-agent target bank.
REQ-013 sw_rden  out  NB_RDAGENT  read enables to read switch.
REQ-014 sw_rdaddr  out  NB_RDAGENT*ADDR_WIDTH  addresses to read switch.
REQ-015 sw_rdselect  out  NB_RDAGENT*SELECT_WIDTH  bank selectors to read switch.
REQ-016 sw_rddata  in  NB_RDAGENT*DATA_WIDTH  per-agent data from read switch.
REQ-017 rsp_valid  out  NB_RDAGENT  one-cycle response strobe per agent.
REQ-018 rsp_err  out  NB_RDAGENT  response flags an out-of-range bank.
REQ-019 rsp_data  out  NB_RDAGENT*DATA_WIDTH  per-agent read data.

Function
REQ-020 Per bank, a round-robin arbiter SHALL grant at most one agent per cycle among agents with req_valid=1 and req_bank equal to that bank.
REQ-021 req_ready[i] SHALL be combinational: 1 iff agent i is granted this cycle; an agent with req_valid=0 SHALL never see req_ready=1.
REQ-022 Each bank's priority pointer SHALL move to (granted agent + 1) mod NB_RDAGENT only on a grant; no grant leaves it unchanged.
REQ-023 Agents SHALL hold req_valid, req_addr and req_bank stable until req_ready; the block SHALL not drop a pending request.
REQ-024 On handshake in cycle T, sw_rden[i]=1 with registered req_addr/req_bank SHALL appear in cycle T+1 for exactly one cycle.
REQ-025 Ungranted agents SHALL have sw_rden[i]=0; sw_rdaddr/sw_rdselect SHALL hold last issued values.
REQ-026 rsp_valid[i] SHALL assert exactly at T+1+BANK_LATENCY via a shift pipeline of sw_rden, with rsp_data = sw_rddata slice that cycle.
REQ-027 rsp_data[i] SHALL be zero whenever rsp_valid[i]=0.
REQ-028 Request with req_bank >= NB_WRAGENT SHALL be accepted at once, SHALL not assert sw_rden, and SHALL return rsp_valid=1, rsp_err=1, rsp_data=0 at the same latency.
REQ-029 Back-to-back handshakes SHALL sustain one request per agent per cycle (full throughput, no bubbles).
REQ-030 Agents targeting distinct banks in the same cycle SHALL all be granted that cycle.

Reset
REQ-031 While areset=1: req_ready, sw_rden, rsp_valid, rsp_err = 0; sw_rdaddr, sw_rdselect, rsp_data = 0; all pointers = 0 (agent 0 highest priority).
REQ-032 Reset mid-operation SHALL flush the response pipeline; no rsp_valid for requests issued before reset.
REQ-033 First grant is possible in the first cycle after areset deasserts.

Structure
REQ-034 SELECT_WIDTH computation and round-robin helper functions SHALL live in a shared package meduram_pkg.
REQ-035 Per-bank arbitration SHALL be a sub-module rr_arbiter (request vector in, one-hot grant out, internal pointer), instantiated NB_WRAGENT times.

Verification
REQ-036 Agents 0,1 both request bank 0 at reset exit, held -> agent 0 granted cycle 0, agent 1 cycle 1; rsp_valid[0] at cycle 2, rsp_valid[1] at cycle 3.
REQ-037 Agent 0 bank 0 addr 0x10, agent 1 bank 1 addr 0x20 same cycle -> both ready; sw_rden=2'b11 next cycle; data from preloaded banks returned two cycles after handshake.
REQ-038 Both agents continuously request bank 1 for 8 cycles -> grants alternate 0,1,0,1...; each gets exactly 4.
REQ-039 NB_WRAGENT=3, agent 1 requests bank 3 -> ready immediately, no sw_rden, rsp_err=1 and rsp_data=0 at T+2.
REQ-040 areset asserted one cycle after handshake -> no rsp_valid; pointers return to 0; next contention grants agent 0.
REQ-041 Agent 0 streams 6 reads to bank 0 alone -> 6 consecutive ready cycles and 6 consecutive rsp_valid cycles, data in order.
